// File: rtl/seq_array_divider.sv
// Sequential restoring divider: one quotient bit per clock, unsigned operands.
// A zero divisor skips the iterations and reports an all-ones quotient with a flag.
module seq_array_divider #(
    parameter int DIVIDEND_W = 8,
    parameter int DIVISOR_W  = 4,
    parameter int CNT_W      = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [DIVIDEND_W-1:0] dividend,
    input  logic [DIVISOR_W-1:0]  divisor,
    output logic                  busy,
    output logic                  done,
    output logic [DIVIDEND_W-1:0] quotient,
    output logic [DIVISOR_W-1:0]  remainder,
    output logic                  div_by_zero
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                  state_reg;
    state_t                  state_next;
    logic [DIVIDEND_W-1:0]   q_reg;
    logic [DIVISOR_W-1:0]    d_reg;
    logic [DIVISOR_W:0]      r_reg;
    logic [CNT_W-1:0]        cnt_reg;
    logic                    dz_pend_reg;
    logic [DIVIDEND_W-1:0]   quotient_reg;
    logic [DIVISOR_W-1:0]    remainder_reg;
    logic                    div_by_zero_reg;

    logic [DIVISOR_W:0]      trial;
    logic                    fits;
    logic [DIVISOR_W:0]      r_step;
    logic [DIVIDEND_W-1:0]   q_step;
    logic                    last_step;

    // One restoring step: bring down the next dividend bit, subtract if it fits.
    assign trial     = {r_reg[DIVISOR_W-1:0], q_reg[DIVIDEND_W-1]};
    assign fits      = (trial >= {1'b0, d_reg});
    assign r_step    = fits ? (trial - {1'b0, d_reg}) : trial;
    assign q_step    = {q_reg[DIVIDEND_W-2:0], fits};
    assign last_step = (cnt_reg == CNT_W'(1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        busy       = 1'b0;
        done       = 1'b0;
        case (state_reg)
            IDLE: begin
                if (start) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                if (last_step) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                busy       = 1'b1;
                done       = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // A zero divisor still spends one RUN cycle so its done lands two cycles after start.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_reg           <= '0;
            d_reg           <= '0;
            r_reg           <= '0;
            cnt_reg         <= '0;
            dz_pend_reg     <= 1'b0;
            quotient_reg    <= '0;
            remainder_reg   <= '0;
            div_by_zero_reg <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        q_reg <= dividend;
                        d_reg <= divisor;
                        r_reg <= '0;
                        if (divisor == '0) begin
                            cnt_reg     <= CNT_W'(1);
                            dz_pend_reg <= 1'b1;
                        end else begin
                            cnt_reg     <= CNT_W'(DIVIDEND_W);
                            dz_pend_reg <= 1'b0;
                        end
                    end
                end
                RUN: begin
                    q_reg   <= q_step;
                    r_reg   <= r_step;
                    cnt_reg <= cnt_reg - CNT_W'(1);
                    if (last_step) begin
                        if (dz_pend_reg) begin
                            quotient_reg    <= '1;
                            remainder_reg   <= '0;
                            div_by_zero_reg <= 1'b1;
                        end else begin
                            quotient_reg    <= q_step;
                            remainder_reg   <= r_step[DIVISOR_W-1:0];
                            div_by_zero_reg <= 1'b0;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign quotient    = quotient_reg;
    assign remainder   = remainder_reg;
    assign div_by_zero = div_by_zero_reg;

endmodule
